// File: rtl/eth_reset_sequencer_if.sv
// ---------------------------------------------------------------------------
// eth_reset_sequencer_if
// Bundles the board-side inputs and the reset outputs of eth_reset_sequencer.
//   board_resetn_in  raw board reset, active-low, asynchronous
//   pll_locked       PLL lock, asynchronous
//   ch_rst_req_n     raw per-port reset buttons, active-low, asynchronous
//   phy_resetn       PHY hardware resets, active-low
//   mac_reset        MAC/fabric resets, active-high
//   sys_ready        global RUN with every port running
//   seq_state        global state: 00 HOLD, 01 POR, 10 SETTLE, 11 RUN
//   heartbeat        free-running heartbeat
// Modports: master = the sequencer, slave = the board/PLL side.
// ---------------------------------------------------------------------------
interface eth_reset_sequencer_if #(
    parameter int NUM_CH = 2
);
    logic              board_resetn_in;
    logic              pll_locked;
    logic [NUM_CH-1:0] ch_rst_req_n;
    logic [NUM_CH-1:0] phy_resetn;
    logic [NUM_CH-1:0] mac_reset;
    logic              sys_ready;
    logic [1:0]        seq_state;
    logic              heartbeat;

    modport master (
        input  board_resetn_in, pll_locked, ch_rst_req_n,
        output phy_resetn, mac_reset, sys_ready, seq_state, heartbeat
    );

    modport slave (
        output board_resetn_in, pll_locked, ch_rst_req_n,
        input  phy_resetn, mac_reset, sys_ready, seq_state, heartbeat
    );
endinterface

// File: rtl/eth_reset_sequencer.sv
// ---------------------------------------------------------------------------
// eth_reset_sequencer
// Board/PHY/MAC reset sequencer for multi-port TSE designs. Debounces the
// board reset and per-port request buttons, gates on PLL lock, then runs a
// PHY POR -> settle -> MAC release sequence. In RUN each port can be
// re-sequenced on its own by a falling edge of its request button.
// Ports:
//   clk    system clock (clk_50_max10)
//   reset  synchronous, active-high reset
//   bus    eth_reset_sequencer_if.master (board inputs, reset outputs)
// Optional feature macro: ETH_RST_STAGGER_EN -- port i leaves PHY reset
//   i*STAGGER_CYCLES after port 0 and the SETTLE count starts at the last
//   release. Undefined: all ports are released on the same edge.
// ---------------------------------------------------------------------------
module eth_reset_sequencer #(
    parameter int NUM_CH         = 2,
    parameter int DB_CYCLES      = 50000,
    parameter int POR_CYCLES     = 1048576,
    parameter int SETTLE_CYCLES  = 250000,
    parameter int PULSE_CYCLES   = 500000,
    parameter int STAGGER_CYCLES = 50000,
    parameter int HB_BIT         = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    eth_reset_sequencer_if.master bus
);

`ifdef ETH_RST_STAGGER_EN
    localparam int STG_CYCLES = STAGGER_CYCLES;
`else
    // Stagger disabled: every port shares offset 0.
    localparam int STG_CYCLES = 0 * STAGGER_CYCLES;
`endif

    // SETTLE covers the staggered releases plus the settle time proper.
    localparam int SET_TOTAL = (NUM_CH - 1) * STG_CYCLES + SETTLE_CYCLES;
    localparam int GCNT_MAX  = (POR_CYCLES > SET_TOTAL) ? POR_CYCLES : SET_TOTAL;
    localparam int GCNT_W    = $clog2(GCNT_MAX + 1);
    localparam int CCNT_MAX  = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CCNT_W    = $clog2(CCNT_MAX + 1);
    localparam int DB_W      = $clog2(DB_CYCLES + 1);
    localparam int NUM_DB    = NUM_CH + 1;   // bit 0 board, bits 1.. requests

    localparam logic [GCNT_W-1:0] POR_LAST   = GCNT_W'(POR_CYCLES - 1);
    localparam logic [GCNT_W-1:0] SET_LAST   = GCNT_W'(SET_TOTAL - 1);
    localparam logic [CCNT_W-1:0] PULSE_LAST = CCNT_W'(PULSE_CYCLES - 1);
    localparam logic [CCNT_W-1:0] CSET_LAST  = CCNT_W'(SETTLE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DB_CYCLES - 1);

    // Board resets idle asserted, buttons idle released.
    localparam logic [NUM_DB-1:0] SYNC_RST = {{NUM_CH{1'b1}}, 1'b0};

    localparam logic [1:0] ST_HOLD   = 2'b00;
    localparam logic [1:0] ST_POR    = 2'b01;
    localparam logic [1:0] ST_SETTLE = 2'b10;
    localparam logic [1:0] ST_RUN    = 2'b11;

    localparam logic [1:0] CH_RUN    = 2'b00;
    localparam logic [1:0] CH_PULSE  = 2'b01;
    localparam logic [1:0] CH_SETTLE = 2'b10;

    // ---------------- input synchronisers ----------------
    logic [NUM_DB-1:0] raw_in;
    logic [NUM_DB-1:0] meta_reg, sync_reg;
    logic              lock_meta_reg, lock_sync_reg;

    assign raw_in = {bus.ch_rst_req_n, bus.board_resetn_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg      <= SYNC_RST;
            sync_reg      <= SYNC_RST;
            lock_meta_reg <= 1'b0;
            lock_sync_reg <= 1'b0;
        end else begin
            meta_reg      <= raw_in;
            sync_reg      <= meta_reg;
            lock_meta_reg <= bus.pll_locked;
            lock_sync_reg <= lock_meta_reg;
        end
    end

    // ---------------- debouncers ----------------
    // The output only moves after DB_CYCLES consecutive samples that differ
    // from it; a single agreeing sample clears the count.
    logic [NUM_DB-1:0] db_vec;

    generate
        for (genvar gi = 0; gi < NUM_DB; gi++) begin : g_db
            logic [DB_W-1:0] db_cnt_reg;
            logic            db_bit_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    db_cnt_reg <= '0;
                    db_bit_reg <= (gi != 0);
                end else if (sync_reg[gi] == db_bit_reg) begin
                    db_cnt_reg <= '0;
                end else if (db_cnt_reg == DB_LAST) begin
                    db_bit_reg <= sync_reg[gi];
                    db_cnt_reg <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + DB_W'(1);
                end
            end

            assign db_vec[gi] = db_bit_reg;
        end
    endgenerate

    // ---------------- global FSM ----------------
    logic [1:0]        state_reg, state_next;
    logic [GCNT_W-1:0] gcnt_reg, gcnt_next;
    logic              power_ok;

    assign power_ok = db_vec[0] & lock_sync_reg;

    always_comb begin
        state_next = state_reg;
        gcnt_next  = gcnt_reg;
        case (state_reg)
            ST_HOLD: begin
                gcnt_next = '0;
                if (power_ok) state_next = ST_POR;
            end
            ST_POR: begin
                if (gcnt_reg == POR_LAST) begin
                    state_next = ST_SETTLE;
                    gcnt_next  = '0;
                end else begin
                    gcnt_next = gcnt_reg + GCNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (gcnt_reg == SET_LAST) begin
                    state_next = ST_RUN;
                    gcnt_next  = '0;
                end else begin
                    gcnt_next = gcnt_reg + GCNT_W'(1);
                end
            end
            default: gcnt_next = '0;
        endcase
        // Losing board reset or lock aborts whatever is in flight.
        if (state_reg != ST_HOLD && !power_ok) begin
            state_next = ST_HOLD;
            gcnt_next  = '0;
        end
    end

    // ---------------- per-port FSMs and output registers ----------------
    logic [NUM_CH-1:0] ch_run_next;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [1:0]        ch_state_reg, ch_state_next;
            logic [CCNT_W-1:0] ch_cnt_reg, ch_cnt_next;
            logic              prev_reg, phy_bit_reg, mac_bit_reg;
            logic              req_fall, g_release;

            assign req_fall = prev_reg & ~db_vec[gi + 1];

            // Global part of this port's PHY release; in SETTLE port gi is
            // released once the count reaches its stagger offset.
            assign g_release = (state_next == ST_RUN) ||
                               ((state_next == ST_SETTLE) &&
                                (int'(gcnt_next) >= gi * STG_CYCLES));

            always_comb begin
                ch_state_next = ch_state_reg;
                ch_cnt_next   = ch_cnt_reg;
                if (state_reg != ST_RUN || state_next != ST_RUN) begin
                    ch_state_next = CH_RUN;
                    ch_cnt_next   = '0;
                end else begin
                    case (ch_state_reg)
                        CH_RUN: begin
                            ch_cnt_next = '0;
                            if (req_fall) ch_state_next = CH_PULSE;
                        end
                        CH_PULSE: begin
                            if (ch_cnt_reg == PULSE_LAST) begin
                                ch_state_next = CH_SETTLE;
                                ch_cnt_next   = '0;
                            end else begin
                                ch_cnt_next = ch_cnt_reg + CCNT_W'(1);
                            end
                        end
                        CH_SETTLE: begin
                            if (ch_cnt_reg == CSET_LAST) begin
                                ch_state_next = CH_RUN;
                                ch_cnt_next   = '0;
                            end else begin
                                ch_cnt_next = ch_cnt_reg + CCNT_W'(1);
                            end
                        end
                        default: begin
                            ch_state_next = CH_RUN;
                            ch_cnt_next   = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    ch_state_reg <= CH_RUN;
                    ch_cnt_reg   <= '0;
                    prev_reg     <= 1'b1;
                    phy_bit_reg  <= 1'b0;
                    mac_bit_reg  <= 1'b1;
                end else begin
                    ch_state_reg <= ch_state_next;
                    ch_cnt_reg   <= ch_cnt_next;
                    prev_reg     <= db_vec[gi + 1];
                    phy_bit_reg  <= g_release && (ch_state_next != CH_PULSE);
                    mac_bit_reg  <= (state_next != ST_RUN) || (ch_state_next != CH_RUN);
                end
            end

            assign ch_run_next[gi]   = (ch_state_next == CH_RUN);
            assign bus.phy_resetn[gi] = phy_bit_reg;
            assign bus.mac_reset[gi]  = mac_bit_reg;
        end
    endgenerate

    // ---------------- state, ready and heartbeat registers ----------------
    logic [HB_BIT:0] hb_cnt_reg;
    logic            sys_ready_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_HOLD;
            gcnt_reg      <= '0;
            sys_ready_reg <= 1'b0;
            hb_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            gcnt_reg      <= gcnt_next;
            sys_ready_reg <= (state_next == ST_RUN) && (&ch_run_next);
            hb_cnt_reg    <= hb_cnt_reg + (HB_BIT + 1)'(1);
        end
    end

    assign bus.sys_ready = sys_ready_reg;
    assign bus.seq_state = state_reg;
    assign bus.heartbeat = hb_cnt_reg[HB_BIT];

endmodule
